// File: rtl/prbs_checker_if.sv
// Signal bundle between a serial PRBS source and the prbs_checker.
// The master drives the bitstream and control inputs; the slave is the checker.
interface prbs_checker_if #(
  parameter int N         = 8,
  parameter int ERR_CNT_W = 16
);
  logic                 load_config_i;
  logic [N-1:0]         taps_i;
  logic                 data_i;
  logic                 valid_i;
  logic                 clear_i;
  logic                 locked_o;
  logic                 error_o;
  logic [ERR_CNT_W-1:0] err_count_o;

  modport master (
    output load_config_i, taps_i, data_i, valid_i, clear_i,
    input  locked_o, error_o, err_count_o
  );

  modport slave (
    input  load_config_i, taps_i, data_i, valid_i, clear_i,
    output locked_o, error_o, err_count_o
  );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising Fibonacci PRBS checker: fills a local window, hunts for
// LOCK_COUNT consecutive correct predictions, then free-runs and counts bit errors.
module prbs_checker #(
  parameter int           N               = 8,
  parameter logic [N-1:0] TAPS            = N'(3),
  parameter bit           VARIABLE_CONFIG = 1'b0,
  parameter int           LOCK_COUNT      = 16,
  parameter int           UNLOCK_WIN      = 64,
  parameter int           UNLOCK_ERRS     = 8,
  parameter int           ERR_CNT_W       = 16
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  prbs_checker_if.slave  bus
);

  localparam int FILL_W  = $clog2(N + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W   = $clog2(UNLOCK_WIN + 1);
  localparam int BAD_W   = $clog2(UNLOCK_ERRS + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(N - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(UNLOCK_WIN - 1);
  localparam logic [BAD_W-1:0]   BAD_LAST   = BAD_W'(UNLOCK_ERRS - 1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t               r_state;
  logic [N-1:0]         r_win;
  logic [N-1:0]         r_taps;
  logic [FILL_W-1:0]    r_fill_cnt;
  logic [MATCH_W-1:0]   r_match_cnt;
  logic [WIN_W-1:0]     r_win_cnt;
  logic [BAD_W-1:0]     r_bad_cnt;
  logic                 r_locked;
  logic                 r_error;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic w_load;
  logic w_pred;
  logic w_mismatch;
  logic w_count_err;

  assign w_load      = VARIABLE_CONFIG && bus.load_config_i;
  assign w_pred      = ^(r_win & r_taps);
  assign w_mismatch  = bus.data_i ^ w_pred;
  // A bit only counts as an error once the reference is free-running.
  assign w_count_err = !w_load && bus.valid_i && (r_state == ST_LOCKED) && w_mismatch;

  // NOTE: every state register is updated with <= in this one clocked block, so
  // all decisions in a cycle see the pre-edge values of the other registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      // NOTE: the window is N flops of state, not a RAM, so it is reset with the rest.
      r_state     <= ST_FILL;
      r_win       <= '0;
      r_taps      <= TAPS;
      r_fill_cnt  <= '0;
      r_match_cnt <= '0;
      r_win_cnt   <= '0;
      r_bad_cnt   <= '0;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_error <= w_count_err;

      if (bus.clear_i) begin
        r_err_count <= '0;
      end else if (w_count_err && (r_err_count != '1)) begin
        r_err_count <= r_err_count + 1'b1;
      end

      if (w_load) begin
        r_taps      <= bus.taps_i;
        r_state     <= ST_FILL;
        r_win       <= '0;
        r_fill_cnt  <= '0;
        r_match_cnt <= '0;
        r_win_cnt   <= '0;
        r_bad_cnt   <= '0;
        r_locked    <= 1'b0;
      end else if (bus.valid_i) begin
        unique case (r_state)
          ST_FILL: begin
            r_win <= {bus.data_i, r_win[N-1:1]};
            if (r_fill_cnt == FILL_LAST) begin
              r_fill_cnt  <= '0;
              r_match_cnt <= '0;
              r_state     <= ST_HUNT;
            end else begin
              r_fill_cnt <= r_fill_cnt + 1'b1;
            end
          end

          ST_HUNT: begin
            r_win <= {bus.data_i, r_win[N-1:1]};
            // An all-zero window predicts zeros trivially; never let it build lock.
            if ((r_win == '0) || w_mismatch) begin
              r_match_cnt <= '0;
            end else if (r_match_cnt == MATCH_LAST) begin
              r_match_cnt <= '0;
              r_win_cnt   <= '0;
              r_bad_cnt   <= '0;
              r_locked    <= 1'b1;
              r_state     <= ST_LOCKED;
            end else begin
              r_match_cnt <= r_match_cnt + 1'b1;
            end
          end

          ST_LOCKED: begin
            // Feed back the prediction so a corrupted input bit never pollutes the reference.
            r_win <= {w_pred, r_win[N-1:1]};
            if (w_mismatch && (r_bad_cnt == BAD_LAST)) begin
              r_fill_cnt <= '0;
              r_win_cnt  <= '0;
              r_bad_cnt  <= '0;
              r_win      <= '0;
              r_locked   <= 1'b0;
              r_state    <= ST_FILL;
            end else if (r_win_cnt == WIN_LAST) begin
              r_win_cnt <= '0;
              r_bad_cnt <= '0;
            end else begin
              r_win_cnt <= r_win_cnt + 1'b1;
              if (w_mismatch) begin
                r_bad_cnt <= r_bad_cnt + 1'b1;
              end
            end
          end

          default: begin
            r_state <= ST_FILL;
          end
        endcase
      end
    end
  end

  assign bus.locked_o    = r_locked;
  assign bus.error_o     = r_error;
  assign bus.err_count_o = r_err_count;

endmodule
